// File: rtl/axi_rd_switch_rr.sv
// N-master AXI read-channel switch with internal round-robin arbitration.
// One burst is in flight at a time; the grant is held from AR acceptance
// until the slave's RLAST beat, and the beat count is checked against ARLEN.
module axi_rd_switch_rr #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned RESP_WIDTH  = 2
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst,
    // Master AR channels
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]    m_arid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_araddr,
    input  logic [NUM_MASTERS*8-1:0]           m_arlen,
    input  logic [NUM_MASTERS*3-1:0]           m_arsize,
    input  logic [NUM_MASTERS*2-1:0]           m_arburst,
    input  logic [NUM_MASTERS-1:0]             m_arvalid,
    output logic [NUM_MASTERS-1:0]             m_arready,
    // Master R channels
    input  logic [NUM_MASTERS-1:0]             m_rready,
    output logic [NUM_MASTERS*ID_WIDTH-1:0]    m_rid,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_rdata,
    output logic [NUM_MASTERS*RESP_WIDTH-1:0]  m_rresp,
    output logic [NUM_MASTERS-1:0]             m_rlast,
    output logic [NUM_MASTERS-1:0]             m_rvalid,
    // Slave AR channel
    output logic [ID_WIDTH-1:0]                s_arid,
    output logic [ADDR_WIDTH-1:0]              s_araddr,
    output logic [7:0]                         s_arlen,
    output logic [2:0]                         s_arsize,
    output logic [1:0]                         s_arburst,
    output logic                               s_arvalid,
    input  logic                               s_arready,
    // Slave R channel
    output logic                               s_rready,
    input  logic [ID_WIDTH-1:0]                s_rid,
    input  logic [DATA_WIDTH-1:0]              s_rdata,
    input  logic [RESP_WIDTH-1:0]              s_rresp,
    input  logic                               s_rlast,
    input  logic                               s_rvalid,
    // Status
    output logic [NUM_MASTERS-1:0]             rd_grant,
    output logic                               rd_busy,
    output logic                               rd_len_err
);

    localparam int unsigned IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    // One extra bit so pointer + offset can exceed NUM_MASTERS-1 before wrapping
    localparam int unsigned IDX_W1 = IDX_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [NUM_MASTERS-1:0]  r_grant;
    logic [NUM_MASTERS-1:0]  w_grant_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        w_ptr_nxt;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_nxt;
    logic                    r_len_err;
    logic                    w_len_err_nxt;

    logic                    w_any;
    logic [IDX_W-1:0]        w_sel;
    logic [IDX_W1-1:0]       w_j;
    logic                    w_in_addr;
    logic                    w_in_data;
    logic                    w_ar_hs;
    logic                    w_r_hs;
    logic [7:0]              w_ar_len;

    assign w_in_addr = (r_state == StAddr);
    assign w_in_data = (r_state == StData);
    assign w_ar_hs   = s_arvalid & s_arready;
    assign w_r_hs    = s_rvalid & s_rready;
    assign w_ar_len  = m_arlen[r_idx*8 +: 8];

    assign rd_grant   = r_grant;
    assign rd_busy    = (r_state != StIdle);
    assign rd_len_err = r_len_err;

    // Round-robin search: first requester at or above the pointer, wrapping
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_j   = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            w_j = {1'b0, r_ptr} + IDX_W1'(i);
            if (w_j >= IDX_W1'(NUM_MASTERS)) begin
                w_j = w_j - IDX_W1'(NUM_MASTERS);
            end
            if (!w_any && m_arvalid[w_j[IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_j[IDX_W-1:0];
            end
        end
    end

    // Next-state logic: arbitration, AR acceptance, beat counting and release
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_len_err_nxt = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_grant_nxt        = '0;
                    w_grant_nxt[w_sel] = 1'b1;
                    w_idx_nxt          = w_sel;
                    w_state_nxt        = StAddr;
                end
            end
            StAddr: begin
                // No timeout: a master dropping ARVALID leaves the switch here
                if (w_ar_hs) begin
                    w_cnt_nxt   = w_ar_len;
                    w_state_nxt = StData;
                end
            end
            StData: begin
                if (w_r_hs) begin
                    w_len_err_nxt = s_rlast ? (r_cnt != 8'd0) : (r_cnt == 8'd0);
                    // Counter saturates at zero; only RLAST ends the burst
                    if (r_cnt != 8'd0) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                    if (s_rlast) begin
                        w_state_nxt = StIdle;
                        w_grant_nxt = '0;
                        w_ptr_nxt   = (r_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, grant, pointer and counter registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_len_err <= w_len_err_nxt;
        end
    end

    // Slave-side routing from the granted master; all zero when idle
    always_comb begin
        s_arid    = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        if (|r_grant) begin
            s_arid    = m_arid[r_idx*ID_WIDTH +: ID_WIDTH];
            s_araddr  = m_araddr[r_idx*ADDR_WIDTH +: ADDR_WIDTH];
            s_arlen   = m_arlen[r_idx*8 +: 8];
            s_arsize  = m_arsize[r_idx*3 +: 3];
            s_arburst = m_arburst[r_idx*2 +: 2];
        end
        s_arvalid = w_in_addr & m_arvalid[r_idx];
        s_rready  = w_in_data & m_rready[r_idx];
    end

    // Master-side routing: only the granted slice is driven, the rest stay zero
    always_comb begin
        m_arready = '0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = '0;
        m_rvalid  = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (r_grant[k]) begin
                m_arready[k] = w_in_addr & s_arready;
                if (w_in_data) begin
                    m_rid[k*ID_WIDTH +: ID_WIDTH]       = s_rid;
                    m_rdata[k*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
                    m_rresp[k*RESP_WIDTH +: RESP_WIDTH] = s_rresp;
                    m_rlast[k]                          = s_rlast;
                    m_rvalid[k]                         = s_rvalid;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_switch_rr.sv
// Scoreboard bench for axi_rd_switch_rr: stimulus pushes expected AR
// handshakes, R beats and length-error pulses; monitors pop and compare.
module tb_axi_rd_switch_rr;

    localparam int NM = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int RW = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [NM*IW-1:0]  m_arid;
    logic [NM*AW-1:0]  m_araddr;
    logic [NM*8-1:0]   m_arlen;
    logic [NM*3-1:0]   m_arsize;
    logic [NM*2-1:0]   m_arburst;
    logic [NM-1:0]     m_arvalid;
    logic [NM-1:0]     m_arready;
    logic [NM-1:0]     m_rready;
    logic [NM*IW-1:0]  m_rid;
    logic [NM*DW-1:0]  m_rdata;
    logic [NM*RW-1:0]  m_rresp;
    logic [NM-1:0]     m_rlast;
    logic [NM-1:0]     m_rvalid;
    logic [IW-1:0]     s_arid;
    logic [AW-1:0]     s_araddr;
    logic [7:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic              s_arvalid;
    logic              s_arready;
    logic              s_rready;
    logic [IW-1:0]     s_rid;
    logic [DW-1:0]     s_rdata;
    logic [RW-1:0]     s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic [NM-1:0]     rd_grant;
    logic              rd_busy;
    logic              rd_len_err;

    axi_rd_switch_rr #(
        .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .RESP_WIDTH(RW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .rd_grant(rd_grant), .rd_busy(rd_busy), .rd_len_err(rd_len_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [NM-1:0] grant;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_t;

    typedef struct {
        int            k;
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } r_t;

    ar_t q_ar[$];
    r_t  q_r[$];
    int  q_err[$];

    int  n_total = 0;
    int  n_bad   = 0;
    int  cyc     = 0;
    bit  pending_err = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // AR, R and length-error monitors
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (s_arvalid && s_arready) begin
                if (q_ar.size() == 0) begin
                    check("ar_unexpected", 1, 0);
                end else begin
                    ar_t e;
                    e = q_ar.pop_front();
                    check("ar_grant", rd_grant, e.grant);
                    check("ar_m_arready", m_arready, e.grant);
                    check("ar_addr", s_araddr, e.addr);
                    check("ar_len", s_arlen, e.len);
                end
            end
            if (|(m_rvalid & m_rready)) begin
                if (q_r.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    r_t e;
                    logic [NM*DW-1:0] exp_data;
                    logic [NM-1:0]    exp_onehot;
                    e = q_r.pop_front();
                    exp_data = '0;
                    exp_data[e.k*DW +: DW] = e.data;
                    exp_onehot = '0;
                    exp_onehot[e.k] = 1'b1;
                    check("r_valid_onehot", m_rvalid, exp_onehot);
                    check("r_data", m_rdata, exp_data);
                    check("r_last", m_rlast[e.k], e.last);
                    check("r_id", m_rid[e.k*IW +: IW], e.id);
                end
            end
            if (rd_len_err) begin
                if (q_err.size() == 0) check("len_err_unexpected", 1, 0);
                else check("len_err_cycle", cyc, q_err.pop_front());
            end
        end
    end

    task automatic req(input int k, input logic [AW-1:0] addr, input logic [7:0] len);
        ar_t e;
        int  lat;
        e.grant = '0;
        e.grant[k] = 1'b1;
        e.addr = addr;
        e.len  = len;
        q_ar.push_back(e);
        m_araddr[k*AW +: AW] = addr;
        m_arlen[k*8 +: 8]    = len;
        m_arid[k*IW +: IW]   = IW'(k);
        m_arvalid[k]         = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sys_clk);
            if (s_arvalid && s_arready && m_arready[k]) begin
                lat = i;
                break;
            end
        end
        // Requested from idle: grant registered at the next edge, handshake seen one cycle on
        check("ar_latency", lat, 2);
        @(posedge sys_clk);
        #1;
        m_arvalid[k] = 1'b0;
    endtask

    task automatic drive_beat(input int k, input logic [DW-1:0] data, input logic last,
                              input bit err);
        r_t e;
        s_rvalid = 1'b1;
        s_rdata  = data;
        s_rlast  = last;
        s_rid    = IW'(k + 1);
        s_rresp  = '0;
        e.k = k;
        e.data = data;
        e.last = last;
        e.id = IW'(k + 1);
        q_r.push_back(e);
        pending_err = err;
    endtask

    task automatic wait_beat();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (s_rready) begin
                ok = 1'b1;
                break;
            end
        end
        check("beat_handshake", ok, 1);
        @(posedge sys_clk);
        #1;
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        if (pending_err) q_err.push_back(cyc);
        pending_err = 1'b0;
    endtask

    task automatic beat(input int k, input logic [DW-1:0] data, input logic last, input bit err);
        drive_beat(k, data, last, err);
        wait_beat();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        m_arid = '0; m_araddr = '0; m_arlen = '0; m_arvalid = '0; m_rready = '0;
        m_arsize = {NM{3'd2}};
        m_arburst = {NM{2'd1}};
        s_arready = 1'b1;
        s_rvalid = 1'b0; s_rlast = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0;

        // Reset state
        repeat (2) @(negedge sys_clk);
        check("rst_grant", rd_grant, 0);
        check("rst_busy", rd_busy, 0);
        check("rst_len_err", rd_len_err, 0);
        check("rst_s_arvalid", s_arvalid, 0);
        check("rst_m_arready", m_arready, 0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // Single master 1, arlen=3, four beats
        m_rready = 3'b010;
        req(1, 32'h0000_1000, 8'd3);
        check("t1_grant", rd_grant, 3'b010);
        check("t1_busy", rd_busy, 1);
        for (int i = 0; i < 4; i++) beat(1, 32'hA0 + i, (i == 3), 1'b0);
        check("t1_release", rd_grant, 0);

        // Round robin from pointer 0 with all three requesting
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        m_rready = 3'b111;
        for (int k = 0; k < NM; k++) begin
            m_araddr[k*AW +: AW] = 32'h2000 + k * 32'h100;
            m_arlen[k*8 +: 8] = 8'd0;
        end
        for (int b = 0; b < 6; b++) begin
            ar_t e;
            e.grant = '0;
            e.grant[b % NM] = 1'b1;
            e.addr = 32'h2000 + (b % NM) * 32'h100;
            e.len = 8'd0;
            q_ar.push_back(e);
        end
        m_arvalid = 3'b111;
        for (int b = 0; b < 6; b++) begin
            beat(b % NM, 32'hB00 + b, 1'b1, 1'b0);
            if (b == 5) m_arvalid = 3'b000;
            check("rr_idle_gap_busy", rd_busy, 0);
            check("rr_idle_gap_grant", rd_grant, 0);
        end

        // Early rlast on beat 2 of arlen=3
        m_rready = 3'b001;
        req(0, 32'h0000_3000, 8'd3);
        beat(0, 32'hC0, 1'b0, 1'b0);
        beat(0, 32'hC1, 1'b1, 1'b1);
        check("t3_release", rd_grant, 0);

        // No rlast on beat 4 of arlen=3; error surfaces during beat 5
        req(0, 32'h0000_4000, 8'd3);
        for (int i = 0; i < 3; i++) beat(0, 32'hD0 + i, 1'b0, 1'b0);
        beat(0, 32'hD3, 1'b0, 1'b1);
        check("t4_still_busy", rd_busy, 1);
        beat(0, 32'hD4, 1'b1, 1'b0);
        check("t4_release", rd_grant, 0);

        // Reset mid-burst after beat 2 of 8
        m_rready = 3'b110;
        req(1, 32'h0000_5000, 8'd7);
        beat(1, 32'hE0, 1'b0, 1'b0);
        beat(1, 32'hE1, 1'b0, 1'b0);
        s_rvalid = 1'b1;
        sys_rst = 1'b1;
        #1;
        check("t5_rst_grant", rd_grant, 0);
        check("t5_rst_busy", rd_busy, 0);
        check("t5_rst_m_rvalid", m_rvalid, 0);
        check("t5_rst_s_rready", s_rready, 0);
        check("t5_rst_m_rdata", m_rdata, 0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        s_rvalid = 1'b0;
        req(2, 32'h0000_5100, 8'd0);
        check("t5_grant_m2", rd_grant, 3'b100);
        beat(2, 32'hE8, 1'b1, 1'b0);

        // RREADY stall: beat held until the granted master is ready
        m_rready = 3'b000;
        req(0, 32'h0000_6000, 8'd1);
        drive_beat(0, 32'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("t6_stall_s_rready", s_rready, 0);
            check("t6_stall_m_rvalid", m_rvalid, 3'b001);
        end
        @(posedge sys_clk); #1;
        m_rready = 3'b001;
        wait_beat();
        beat(0, 32'hF1, 1'b1, 1'b0);
        check("t6_release", rd_grant, 0);

        repeat (4) @(posedge sys_clk);
        #1;
        check("end_ar_queue", q_ar.size(), 0);
        check("end_r_queue", q_r.size(), 0);
        check("end_err_queue", q_err.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
